prbs_checker: RTL and testbench

- Receive-side counterpart of the team's 3-bit LFSR PRBS generator (polynomial x^3+x^2+1, period 7).
- Accepts the serial PRBS stream one bit per valid cycle and self-synchronises a local LFSR to it.
- Declares lock once synchronised, then flags and counts bit errors against the free-running local sequence.
- Sits at the far end of a serial link or loopback path as the link BER monitor.

---
 rtl/prbs_checker.sv | 178 +++++++++++++++++
 tb/tb_prbs_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: locks a local LFSR onto the received serial stream,
// then flags, counts and windows bit errors against the free-running local sequence.
module prbs_checker #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] TAPS     = 3'b110,
    parameter int               LOCK_CNT = 8,
    parameter int               WINDOW   = 16,
    parameter int               LOSS_ERR = 4,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_ERR + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_ERR - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic predict(input logic [WIDTH-1:0] h);
        return ^(h & TAPS);
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] hist_r, hist_s;
    logic [FW-1:0]    fill_r, fill_s;
    logic [MW-1:0]    match_r, match_s;
    logic [WW-1:0]    win_r, win_s;
    logic [EW-1:0]    win_err_r, win_err_s;
    logic             locked_r, locked_s;
    logic             err_r, err_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic             pred_s, miss_s, err_inc_s, bit_inc_s;

    // Next-state, history and counter computation
    always_comb begin
        state_s   = state_r;
        hist_s    = hist_r;
        fill_s    = fill_r;
        match_s   = match_r;
        win_s     = win_r;
        win_err_s = win_err_r;
        locked_s  = locked_r;
        err_s     = 1'b0;
        err_inc_s = 1'b0;
        bit_inc_s = 1'b0;
        pred_s    = predict(hist_r);
        miss_s    = din ^ pred_s;

        if (din_valid) begin
            case (state_r)
                ST_FILL: begin
                    hist_s = {hist_r[WIDTH-2:0], din};
                    if (fill_r == FILL_LAST) begin
                        state_s = ST_SEARCH;
                        fill_s  = '0;
                    end else begin
                        fill_s = fill_r + FW'(1);
                    end
                end
                ST_SEARCH: begin
                    hist_s = {hist_r[WIDTH-2:0], din};
                    // An all-zero history is the LFSR lockup state and never counts as a match
                    if (!miss_s && (hist_r != '0)) begin
                        if (match_r == MATCH_LAST) begin
                            state_s   = ST_LOCKED;
                            locked_s  = 1'b1;
                            match_s   = '0;
                            win_s     = '0;
                            win_err_s = '0;
                        end else begin
                            match_s = match_r + MW'(1);
                        end
                    end else begin
                        match_s = '0;
                    end
                end
                ST_LOCKED: begin
                    hist_s    = {hist_r[WIDTH-2:0], pred_s};
                    bit_inc_s = 1'b1;
                    err_s     = miss_s;
                    err_inc_s = miss_s;
                    if (miss_s && (win_err_r == ERR_LAST)) begin
                        state_s   = ST_SEARCH;
                        locked_s  = 1'b0;
                        hist_s    = {hist_r[WIDTH-2:0], din};
                        match_s   = '0;
                        win_s     = '0;
                        win_err_s = '0;
                    end else if (win_r == WIN_LAST) begin
                        win_s     = '0;
                        win_err_s = '0;
                    end else begin
                        win_s     = win_r + WW'(1);
                        win_err_s = win_err_r + EW'(miss_s);
                    end
                end
                default: begin
                    state_s  = ST_FILL;
                    hist_s   = '0;
                    fill_s   = '0;
                    match_s  = '0;
                    locked_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        if (clr_cnt) begin
            err_cnt_s = '0;
            bit_cnt_s = '0;
        end else begin
            if (err_inc_s && (err_cnt_r != '1)) begin
                err_cnt_s = err_cnt_r + CNT_W'(1);
            end else begin
                err_cnt_s = err_cnt_r;
            end
            if (bit_inc_s && (bit_cnt_r != '1)) begin
                bit_cnt_s = bit_cnt_r + CNT_W'(1);
            end else begin
                bit_cnt_s = bit_cnt_r;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (R) begin
            state_r   <= ST_FILL;
            hist_r    <= '0;
            fill_r    <= '0;
            match_r   <= '0;
            win_r     <= '0;
            win_err_r <= '0;
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
            bit_cnt_r <= '0;
        end else begin
            state_r   <= state_s;
            hist_r    <= hist_s;
            fill_r    <= fill_s;
            match_r   <= match_s;
            win_r     <= win_s;
            win_err_r <= win_err_s;
            locked_r  <= locked_s;
            err_r     <= err_s;
            err_cnt_r <= err_cnt_s;
            bit_cnt_r <= bit_cnt_s;
        end
    end

    assign locked  = locked_r;
    assign err     = err_r;
    assign err_cnt = err_cnt_r;
    assign bit_cnt = bit_cnt_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker using the 7-bit sequence 1,0,0,1,0,1,1.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        R;
    logic        din_valid;
    logic        din;
    logic        clr_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [15:0] bit_cnt;

    int checks = 0;
    int errors = 0;
    int p      = 0;
    logic pat [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    prbs_checker dut (
        .clk       (clk),
        .R         (R),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // One clock with the next stream bit (optionally inverted); outputs sampled 1 ns after the edge
    task automatic step(input logic v, input logic flip, input logic c);
        din_valid = v;
        din       = pat[p] ^ flip;
        clr_cnt   = c;
        @(posedge clk);
        #1;
        if (v) p = (p + 1) % 7;
    endtask

    task automatic step_raw(input logic v, input logic d);
        din_valid = v;
        din       = d;
        clr_cnt   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        R = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        R = 1'b0;

        // Clean stream: lock after the 11th valid bit
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("acq_err", err, 0);
            chk("acq_locked", locked, (i == 11) ? 1 : 0);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("run_err", err, 0);
        end
        chk("run_bit_cnt", bit_cnt, 10);
        chk("run_err_cnt", err_cnt, 0);
        chk("run_locked", locked, 1);

        // Single flipped bit: one err pulse, no propagation
        step(1'b1, 1'b1, 1'b0);
        chk("flip1_err", err, 1);
        chk("flip1_err_cnt", err_cnt, 1);
        chk("flip1_locked", locked, 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("flip1_after_err", err, 0);
        end
        chk("flip1_after_cnt", err_cnt, 1);
        chk("flip1_bit_cnt", bit_cnt, 17);

        // Clear with no valid bit
        step(1'b0, 1'b0, 1'b1);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_bit_cnt", bit_cnt, 0);
        chk("clr_locked", locked, 1);

        // Four errors in one window: loss of lock on the 4th
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            chk("loss_err", err, (i % 2 == 0) ? 1 : 0);
            chk("loss_locked", locked, (i == 6) ? 0 : 1);
        end
        chk("loss_err_cnt", err_cnt, 4);
        chk("loss_bit_cnt", bit_cnt, 7);

        // Relock: two early mismatches against the corrupted history, then 8 matches
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("relock_err", err, 0);
            chk("relock_locked", locked, (i == 11) ? 1 : 0);
        end
        chk("relock_err_cnt", err_cnt, 4);

        // clr_cnt coinciding with an error
        step(1'b1, 1'b1, 1'b1);
        chk("clrerr_err", err, 1);
        chk("clrerr_err_cnt", err_cnt, 0);
        chk("clrerr_bit_cnt", bit_cnt, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("clrerr_next_err", err, 0);
        chk("clrerr_next_cnt", err_cnt, 0);
        chk("clrerr_next_bits", bit_cnt, 1);

        // Reset mid-lock with a simultaneous errored valid bit
        R = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        R = 1'b0;
        chk("midrst_locked", locked, 0);
        chk("midrst_err", err, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_bit_cnt", bit_cnt, 0);
        p = 0;

        // din_valid toggling: lock point counted in valid bits, err low on gaps
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("tog_lock_v", locked, (i == 11) ? 1 : 0);
            step(1'b0, 1'b1, 1'b0);
            chk("tog_err_gap", err, 0);
            chk("tog_lock_gap", locked, (i == 11) ? 1 : 0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("tog_flip_err", err, 1);
        step(1'b0, 1'b1, 1'b0);
        chk("tog_flip_gap_err", err, 0);
        chk("tog_err_cnt", err_cnt, 1);
        chk("tog_bit_cnt", bit_cnt, 1);

        // All-zero stream never locks
        R = 1'b1;
        step_raw(1'b0, 1'b0);
        R = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step_raw(1'b1, 1'b0);
            chk("zero_locked", locked, 0);
            chk("zero_err", err, 0);
        end
        chk("zero_err_cnt", err_cnt, 0);
        chk("zero_bit_cnt", bit_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
